// File: rtl/kbd_pkg.sv
// kbd_pkg: scancode layout and scanner FSM encoding shared by the keyboard scanner
package kbd_pkg;
  localparam int KBD_FIELD_W = 3;
  localparam int KBD_EVENT_W = 7;
  localparam int KBD_PRESSED_BIT = 6;
  localparam int KBD_ROW_LSB = 3;
  localparam int KBD_COL_LSB = 0;
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, EMIT, NEXT} kbd_state_e;
  function automatic logic [KBD_EVENT_W-1:0] kbd_event(input logic pressed,
      input logic [KBD_FIELD_W-1:0] row, input logic [KBD_FIELD_W-1:0] col);
    logic [KBD_EVENT_W-1:0] e;
    e = '0;
    e[KBD_PRESSED_BIT] = pressed;
    e[KBD_ROW_LSB +: KBD_FIELD_W] = row;
    e[KBD_COL_LSB +: KBD_FIELD_W] = col;
    return e;
  endfunction
endpackage

// File: rtl/keyboard_matrix_scanner_if.sv
// keyboard_matrix_scanner_if: scancode event stream with valid/ready handshake
interface keyboard_matrix_scanner_if;
  import kbd_pkg::*;
  logic event_valid_o;
  logic [KBD_EVENT_W-1:0] event_data_o;
  logic event_ready_i;
  modport master(output event_valid_o, output event_data_o, input event_ready_i);
  modport slave(input event_valid_o, input event_data_o, output event_ready_i);
endinterface

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: first-word fall-through sync FIFO; a full FIFO refuses pushes even when popped
module kbd_event_fifo #(
  parameter int W = 7,
  parameter int DEPTH = 4
) (
  input  logic         bus_clk,
  input  logic         bus_reset_n,
  input  logic         push,
  input  logic [W-1:0] data,
  output logic         full,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign valid = count != '0;
  assign head = mem[rd];
  assign do_push = push && !full;
  assign do_pop = pop && valid;
  always_ff @(posedge bus_clk)
    if (do_push) mem[wr] <= data;
  always_ff @(posedge bus_clk or negedge bus_reset_n)
    if (!bus_reset_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/keyboard_matrix_scanner.sv
// keyboard_matrix_scanner: row-strobed membrane scanner with per-key debounce and event queue
module keyboard_matrix_scanner
  import kbd_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 7,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset_n,
  input  logic                     scan_enable_i,
  input  logic [COLS-1:0]          keyb_col_i,
  output logic [ROWS-1:0]          keyb_rows_o,
  keyboard_matrix_scanner_if.master evt,
  output logic [ROWS*COLS-1:0]     key_state_o,
  output logic                     any_key_o,
  output logic                     scan_done_o
);
  localparam int KEYS = ROWS * COLS;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int KW = KEYS > 1 ? $clog2(KEYS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  kbd_state_e state, state_n;
  logic [COLS-1:0] col_meta, col_sync, sample;
  logic [RW-1:0] row;
  logic [CLW-1:0] col;
  logic [SW-1:0] settle;
  logic [DW-1:0] deb [KEYS];
  logic [KEYS-1:0] key_state;
  logic [KW-1:0] idx;
  logic diff, due, push, full;
  assign idx = KW'(row) * KW'(COLS) + KW'(col);
  assign diff = sample[col] != key_state[idx];
  assign due = diff && deb[idx] == DW'(DEBOUNCE_SCANS - 1);
  assign push = state == EMIT && due && !full;
  assign key_state_o = key_state;
  assign any_key_o = |key_state;
  always_ff @(posedge bus_clk or negedge bus_reset_n)
    if (!bus_reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = scan_enable_i ? DRIVE : IDLE;
      DRIVE:  state_n = settle == SW'(SETTLE_CYCLES - 1) ? SAMPLE : DRIVE;
      SAMPLE: state_n = EMIT;
      EMIT:   state_n = col == CLW'(COLS - 1) ? NEXT : EMIT;
      NEXT:   state_n = scan_enable_i ? DRIVE : IDLE;
      default: state_n = IDLE;
    endcase
    keyb_rows_o = (state == DRIVE || state == SAMPLE) ? ~(ROWS'(1) << row) : '1;
    scan_done_o = state == NEXT && row == RW'(ROWS - 1);
  end
  // Columns idle high through the synchronizer so reset never looks like a press.
  always_ff @(posedge bus_clk or negedge bus_reset_n)
    if (!bus_reset_n) begin
      col_meta <= '1;
      col_sync <= '1;
      sample <= '0;
      row <= '0;
      col <= '0;
      settle <= '0;
      key_state <= '0;
      for (int i = 0; i < KEYS; i++) deb[i] <= '0;
    end else begin
      col_meta <= keyb_col_i;
      col_sync <= col_meta;
      settle <= state == DRIVE ? settle + 1'b1 : '0;
      col <= state == EMIT ? col + 1'b1 : '0;
      if (state == SAMPLE) sample <= ~col_sync;
      if (state == NEXT) row <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
      // A due change blocked by a full queue keeps its count and retries next scan.
      if (state == EMIT) begin
        if (!diff) deb[idx] <= '0;
        else if (!due) deb[idx] <= deb[idx] + 1'b1;
        else if (!full) begin
          deb[idx] <= '0;
          key_state[idx] <= sample[col];
        end
      end
    end
  kbd_event_fifo #(.W(KBD_EVENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .bus_clk(bus_clk),
    .bus_reset_n(bus_reset_n),
    .push(push),
    .data(kbd_event(sample[col], KBD_FIELD_W'(row), KBD_FIELD_W'(col))),
    .full(full),
    .pop(evt.event_ready_i),
    .valid(evt.event_valid_o),
    .head(evt.event_data_o)
  );
endmodule
